// File: rtl/run_monitor_pkg.sv
// Purpose: shared FSM state encoding, counter width and saturating increment for run_monitor.
// Latency: none, declarations only.
// Backpressure: none.
package run_monitor_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DUMP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/run_monitor_dump.sv
// Purpose: issues data-memory reads 0..DUMP_WORDS-1 and presents each word through one output register.
// Latency: read issued in cycle t, word captured at the end of t+1, visible as valid from t+2.
// Backpressure: valid/data hold until ready; a read is issued only when the register is empty or being accepted.
module run_monitor_dump
   import run_monitor_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int DUMP_WORDS = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [DATA_W-1:0]             rdata,
   input  logic                          ready,
   output logic                          rd_en,
   output logic [$clog2(DUMP_WORDS)-1:0] addr,
   output logic                          valid,
   output logic [DATA_W-1:0]             data,
   output logic                          last_accept
);

   localparam int AW = $clog2(DUMP_WORDS);

   logic          issued_all;
   logic          pend;
   logic [AW-1:0] acc_cnt;
   logic          accept;
   logic          take;

   // A read still in flight always finds room: reads are only issued when the register
   // frees up, and while a landed word waits no new read is issued, so the memory keeps
   // presenting it on rdata until the register can take it.
   assign accept      = valid && ready;
   assign take        = pend && (!valid || ready);
   assign rd_en       = enable && !issued_all && (!valid || ready);
   assign last_accept = accept && (acc_cnt == AW'(DUMP_WORDS - 1));

   // Read address walk, in-flight tracking, output register and accepted-word count.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr       <= '0;
         issued_all <= 1'b0;
         pend       <= 1'b0;
         acc_cnt    <= '0;
         valid      <= 1'b0;
         data       <= '0;
      end else begin
         if (rd_en) begin
            if (addr == AW'(DUMP_WORDS - 1)) begin
               issued_all <= 1'b1;
            end else begin
               addr <= addr + AW'(1);
            end
         end
         pend <= rd_en || (pend && !take);
         if (take) begin
            valid <= 1'b1;
            data  <= rdata;
         end else if (accept) begin
            valid <= 1'b0;
         end
         if (accept) begin
            acc_cnt <= acc_cnt + AW'(1);
         end
      end
   end

endmodule

// File: rtl/run_monitor.sv
// Purpose: CPU run supervisor - reset hold, run until halt store (or cycle budget when RUN_MONITOR_TIMEOUT_EN is defined), then dump data memory.
// Latency: halt store moves to DUMP on the next edge; first dump word is valid two edges after DUMP entry.
// Backpressure: dump_valid/dump_data hold until dump_ready; one word per cycle while dump_ready stays high.
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                ADDR_W     = 32,
   parameter int                RST_CYCLES = 1,
   parameter int                MAX_CYCLES = 210,
   parameter logic [ADDR_W-1:0] HALT_ADDR  = 'hFC,
   parameter int                DUMP_WORDS = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          cpu_reset,
   input  logic                          write_enable,
   input  logic [ADDR_W-1:0]             address_to_mem,
   input  logic [DATA_W-1:0]             data_to_mem,
   output logic                          dump_rd_en,
   output logic [$clog2(DUMP_WORDS)-1:0] dump_addr,
   input  logic [DATA_W-1:0]             dump_rdata,
   output logic                          dump_valid,
   output logic [DATA_W-1:0]             dump_data,
   input  logic                          dump_ready,
   output logic                          done,
   output logic                          halted,
   output logic                          timed_out,
   output logic [DATA_W-1:0]             halt_code,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [CNT_W-1:0]              store_count
);

   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   // Out-of-range configurations are rejected while elaborating.
   if (RST_CYCLES < 1 || MAX_CYCLES < 1 || DUMP_WORDS < 2) begin : g_bad_params
      $error("run_monitor: RST_CYCLES, MAX_CYCLES must be >= 1 and DUMP_WORDS >= 2");
   end

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              halt_store;
   logic              budget_hit;
   logic              dump_en;
   logic              last_accept;

   assign halt_store = write_enable && (address_to_mem == HALT_ADDR);
   assign dump_en    = (state == ST_DUMP);

`ifdef RUN_MONITOR_TIMEOUT_EN
   logic timeout_q;

   // The last budgeted RUN cycle is the one entered with MAX_CYCLES-1 cycles already counted.
   assign budget_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));
   assign timed_out  = timeout_q;

   // Budget expiry flag; a halt store in the same cycle takes precedence.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else if (state == ST_RUN && budget_hit && !halt_store) begin
         timeout_q <= 1'b1;
      end
   end
`else
   assign budget_hit = 1'b0;
   assign timed_out  = 1'b0;
`endif

   // Sequencer HOLD -> RUN -> DUMP -> DONE with registered status outputs and run counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_HOLD;
         hold_cnt    <= '0;
         cpu_reset   <= 1'b1;
         done        <= 1'b0;
         halted      <= 1'b0;
         halt_code   <= '0;
         cycle_count <= '0;
         store_count <= '0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                  state     <= ST_RUN;
                  cpu_reset <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               cycle_count <= sat_inc(cycle_count);
               if (write_enable) begin
                  store_count <= sat_inc(store_count);
               end
               if (halt_store) begin
                  halted    <= 1'b1;
                  halt_code <= data_to_mem;
                  state     <= ST_DUMP;
                  cpu_reset <= 1'b1;
               end else if (budget_hit) begin
                  state     <= ST_DUMP;
                  cpu_reset <= 1'b1;
               end
            end
            ST_DUMP: begin
               if (last_accept) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_DONE;
            end
         endcase
      end
   end

   run_monitor_dump #(
      .DATA_W     (DATA_W),
      .DUMP_WORDS (DUMP_WORDS)
   ) u_dump (
      .clk         (clk),
      .reset       (reset),
      .enable      (dump_en),
      .rdata       (dump_rdata),
      .ready       (dump_ready),
      .rd_en       (dump_rd_en),
      .addr        (dump_addr),
      .valid       (dump_valid),
      .data        (dump_data),
      .last_accept (last_accept)
   );

endmodule

// File: tb/tb_run_monitor.sv
// Purpose: directed self-checking bench for run_monitor (reset hold, halt, budget, dump handshake, mid-dump reset).
// Latency: inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
// Backpressure: the dump consumer drives dump_ready toggling or held high; memory word i holds i*4.
module tb_run_monitor;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int RST_CYCLES = 3;
   localparam int MAX_CYCLES = 50;
   localparam int DUMP_WORDS = 64;
   localparam int AW         = $clog2(DUMP_WORDS);
   localparam logic [ADDR_W-1:0] HALT = 'hFC;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_reset;
   logic              write_enable;
   logic [ADDR_W-1:0] address_to_mem;
   logic [DATA_W-1:0] data_to_mem;
   logic              dump_rd_en;
   logic [AW-1:0]     dump_addr;
   logic [DATA_W-1:0] dump_rdata;
   logic              dump_valid;
   logic [DATA_W-1:0] dump_data;
   logic              dump_ready;
   logic              done;
   logic              halted;
   logic              timed_out;
   logic [DATA_W-1:0] halt_code;
   logic [31:0]       cycle_count;
   logic [31:0]       store_count;

   int n_vec = 0;
   int n_bad = 0;

   logic [DATA_W-1:0] mem [DUMP_WORDS];

   run_monitor #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .RST_CYCLES (RST_CYCLES),
      .MAX_CYCLES (MAX_CYCLES),
      .HALT_ADDR  (HALT),
      .DUMP_WORDS (DUMP_WORDS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_reset      (cpu_reset),
      .write_enable   (write_enable),
      .address_to_mem (address_to_mem),
      .data_to_mem    (data_to_mem),
      .dump_rd_en     (dump_rd_en),
      .dump_addr      (dump_addr),
      .dump_rdata     (dump_rdata),
      .dump_valid     (dump_valid),
      .dump_data      (dump_data),
      .dump_ready     (dump_ready),
      .done           (done),
      .halted         (halted),
      .timed_out      (timed_out),
      .halt_code      (halt_code),
      .cycle_count    (cycle_count),
      .store_count    (store_count)
   );

   always #5 clk = ~clk;

   // Synchronous data memory: word appears one cycle after the read and holds until the next read.
   always @(posedge clk) begin
      if (dump_rd_en) dump_rdata <= mem[dump_addr];
   end

   task automatic do_reset();
      reset = 1'b1;
      write_enable = 1'b0;
      dump_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Wait for the RUN phase; returns at the falling edge inside RUN cycle 1.
   task automatic wait_run();
      for (int i = 0; i < 20 && cpu_reset !== 1'b0; i++) @(negedge clk);
      if (cpu_reset !== 1'b0) begin
         n_vec++; n_bad++;
         $display("FAIL wait_run cpu_reset got %0h exp 0 within 20 cycles", cpu_reset);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      write_enable = 1'b1; address_to_mem = HALT; data_to_mem = 'hDEAD; dump_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++; if (cpu_reset !== 1'b1)   begin n_bad++; $display("FAIL rst_cpu_reset got %0h exp 1", cpu_reset); end
      n_vec++; if (dump_rd_en !== 1'b0)  begin n_bad++; $display("FAIL rst_rd_en got %0h exp 0", dump_rd_en); end
      n_vec++; if (dump_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_valid got %0h exp 0", dump_valid); end
      n_vec++; if (done !== 1'b0)        begin n_bad++; $display("FAIL rst_done got %0h exp 0", done); end
      n_vec++; if (halted !== 1'b0)      begin n_bad++; $display("FAIL rst_halted got %0h exp 0", halted); end
      n_vec++; if (timed_out !== 1'b0)   begin n_bad++; $display("FAIL rst_timed_out got %0h exp 0", timed_out); end
      n_vec++; if (halt_code !== '0)     begin n_bad++; $display("FAIL rst_halt_code got %0h exp 0", halt_code); end
      n_vec++; if (cycle_count !== '0)   begin n_bad++; $display("FAIL rst_cycle_count got %0d exp 0", cycle_count); end
      n_vec++; if (store_count !== '0)   begin n_bad++; $display("FAIL rst_store_count got %0d exp 0", store_count); end
      n_vec++; if (dump_addr !== '0)     begin n_bad++; $display("FAIL rst_dump_addr got %0d exp 0", dump_addr); end
      write_enable = 1'b0; dump_ready = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_hold();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_reset !== 1'b1) break;
         cnt++;
         @(negedge clk);
      end
      n_vec++; if (cnt != RST_CYCLES) begin n_bad++; $display("FAIL hold_cycles got %0d exp %0d", cnt, RST_CYCLES); end
      n_vec++; if (cpu_reset !== 1'b0) begin n_bad++; $display("FAIL hold_release got %0h exp 0", cpu_reset); end
      n_vec++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL hold_cycle_count got %0d exp 0", cycle_count); end
   endtask

   // Stores at cycles 3,7,11 (ordinary), 15 (0xF8, next to halt), halt at cycle 20.
   task automatic test_halt();
      for (int k = 1; k <= 20; k++) begin
         if (k == 11) begin
            n_vec++; if (cycle_count !== 32'd10) begin n_bad++; $display("FAIL run_cycle_count got %0d exp 10", cycle_count); end
            n_vec++; if (store_count !== 32'd2)  begin n_bad++; $display("FAIL run_store_count got %0d exp 2", store_count); end
         end
         write_enable = (k == 3 || k == 7 || k == 11 || k == 15 || k == 20);
         address_to_mem = (k == 20) ? HALT : (k == 15) ? ADDR_W'('hF8) : ADDR_W'('h10 + k);
         data_to_mem = (k == 20) ? DATA_W'(1) : DATA_W'(k);
         @(negedge clk);
      end
      write_enable = 1'b0;
      n_vec++; if (halted !== 1'b1)         begin n_bad++; $display("FAIL halt_flag got %0h exp 1", halted); end
      n_vec++; if (halt_code !== 32'h1)     begin n_bad++; $display("FAIL halt_code got %0h exp 1", halt_code); end
      n_vec++; if (cycle_count !== 32'd20)  begin n_bad++; $display("FAIL halt_cycle_count got %0d exp 20", cycle_count); end
      n_vec++; if (store_count !== 32'd5)   begin n_bad++; $display("FAIL halt_store_count got %0d exp 5", store_count); end
      n_vec++; if (cpu_reset !== 1'b1)      begin n_bad++; $display("FAIL halt_cpu_reset got %0h exp 1", cpu_reset); end
      n_vec++; if (timed_out !== 1'b0)      begin n_bad++; $display("FAIL halt_timed_out got %0h exp 0", timed_out); end
      n_vec++; if (dump_rd_en !== 1'b1 || dump_addr !== '0) begin n_bad++; $display("FAIL halt_dump_start got rd_en=%0h addr=%0d exp rd_en=1 addr=0", dump_rd_en, dump_addr); end
      // A store after the run must be ignored.
      write_enable = 1'b1; address_to_mem = HALT; data_to_mem = 'h55;
      @(negedge clk);
      write_enable = 1'b0;
      n_vec++; if (store_count !== 32'd5 || halt_code !== 32'h1) begin n_bad++; $display("FAIL post_run_store got count=%0d code=%0h exp count=5 code=1", store_count, halt_code); end
   endtask

   task automatic test_dump_toggle();
      int got;
      logic stalled;
      logic [DATA_W-1:0] held;
      got = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 400 && got < DUMP_WORDS; cyc++) begin
         dump_ready = cyc[0];
         if (stalled) begin
            n_vec++; if (dump_valid !== 1'b1 || dump_data !== held) begin n_bad++; $display("FAIL dump_hold got valid=%0h data=%0h exp valid=1 data=%0h", dump_valid, dump_data, held); end
         end
         if (dump_valid === 1'b1 && dump_ready) begin
            n_vec++; if (dump_data !== DATA_W'(got * 4)) begin n_bad++; $display("FAIL dump_word%0d got %0h exp %0h", got, dump_data, got * 4); end
            got++;
         end
         stalled = (dump_valid === 1'b1) && !dump_ready;
         held = dump_data;
         @(negedge clk);
      end
      dump_ready = 1'b0;
      n_vec++; if (got != DUMP_WORDS) begin n_bad++; $display("FAIL dump_count got %0d exp %0d", got, DUMP_WORDS); end
      n_vec++; if (done !== 1'b1)       begin n_bad++; $display("FAIL dump_done got %0h exp 1", done); end
      n_vec++; if (dump_valid !== 1'b0 || dump_rd_en !== 1'b0) begin n_bad++; $display("FAIL done_idle got valid=%0h rd_en=%0h exp 0 0", dump_valid, dump_rd_en); end
      repeat (3) @(negedge clk);
      n_vec++; if (done !== 1'b1 || dump_valid !== 1'b0) begin n_bad++; $display("FAIL done_sticky got done=%0h valid=%0h exp 1 0", done, dump_valid); end
   endtask

   task automatic test_timeout();
      do_reset();
      wait_run();
`ifdef RUN_MONITOR_TIMEOUT_EN
      repeat (MAX_CYCLES - 1) @(negedge clk);
      n_vec++; if (timed_out !== 1'b0 || cycle_count !== 32'(MAX_CYCLES - 1)) begin n_bad++; $display("FAIL budget_early got to=%0h cnt=%0d exp 0 %0d", timed_out, cycle_count, MAX_CYCLES - 1); end
      @(negedge clk);
      n_vec++; if (timed_out !== 1'b1 || halted !== 1'b0) begin n_bad++; $display("FAIL budget_expire got to=%0h halted=%0h exp 1 0", timed_out, halted); end
      n_vec++; if (cpu_reset !== 1'b1 || cycle_count !== 32'(MAX_CYCLES)) begin n_bad++; $display("FAIL budget_dump got cpu_reset=%0h cnt=%0d exp 1 %0d", cpu_reset, cycle_count, MAX_CYCLES); end
      do_reset();
      wait_run();
      repeat (MAX_CYCLES - 1) @(negedge clk);
      write_enable = 1'b1; address_to_mem = HALT; data_to_mem = 'hAB;
      @(negedge clk);
      write_enable = 1'b0;
      n_vec++; if (halted !== 1'b1 || timed_out !== 1'b0) begin n_bad++; $display("FAIL halt_vs_budget got halted=%0h to=%0h exp 1 0", halted, timed_out); end
      n_vec++; if (halt_code !== 32'hAB || cycle_count !== 32'(MAX_CYCLES)) begin n_bad++; $display("FAIL halt_vs_budget_vals got code=%0h cnt=%0d exp AB %0d", halt_code, cycle_count, MAX_CYCLES); end
`else
      repeat (MAX_CYCLES + 10) @(negedge clk);
      n_vec++; if (timed_out !== 1'b0 || cpu_reset !== 1'b0) begin n_bad++; $display("FAIL no_budget got to=%0h cpu_reset=%0h exp 0 0", timed_out, cpu_reset); end
      n_vec++; if (cycle_count !== 32'(MAX_CYCLES + 10)) begin n_bad++; $display("FAIL no_budget_count got %0d exp %0d", cycle_count, MAX_CYCLES + 10); end
`endif
   endtask

   task automatic test_reset_mid_dump();
      do_reset();
      wait_run();
      write_enable = 1'b1; address_to_mem = HALT; data_to_mem = 'h7;
      @(negedge clk);
      write_enable = 1'b0;
      dump_ready = 1'b1;
      for (int i = 0; i < 100 && dump_addr !== AW'(10); i++) @(negedge clk);
      n_vec++; if (dump_addr !== AW'(10)) begin n_bad++; $display("FAIL mid_dump_reach got addr=%0d exp 10", dump_addr); end
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (cpu_reset !== 1'b1)   begin n_bad++; $display("FAIL mid_cpu_reset got %0h exp 1", cpu_reset); end
      n_vec++; if (dump_rd_en !== 1'b0)  begin n_bad++; $display("FAIL mid_rd_en got %0h exp 0", dump_rd_en); end
      n_vec++; if (dump_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_valid got %0h exp 0", dump_valid); end
      n_vec++; if (done !== 1'b0)        begin n_bad++; $display("FAIL mid_done got %0h exp 0", done); end
      n_vec++; if (halted !== 1'b0)      begin n_bad++; $display("FAIL mid_halted got %0h exp 0", halted); end
      n_vec++; if (timed_out !== 1'b0)   begin n_bad++; $display("FAIL mid_timed_out got %0h exp 0", timed_out); end
      n_vec++; if (halt_code !== '0)     begin n_bad++; $display("FAIL mid_halt_code got %0h exp 0", halt_code); end
      n_vec++; if (cycle_count !== '0)   begin n_bad++; $display("FAIL mid_cycle_count got %0d exp 0", cycle_count); end
      n_vec++; if (store_count !== '0)   begin n_bad++; $display("FAIL mid_store_count got %0d exp 0", store_count); end
      n_vec++; if (dump_addr !== '0)     begin n_bad++; $display("FAIL mid_dump_addr got %0d exp 0", dump_addr); end
      reset = 1'b0;
   endtask

   // Rerun after the mid-dump reset with dump_ready held high: one word per cycle.
   task automatic test_back_to_back();
      int got;
      int first;
      int last;
      got = 0; first = -1; last = -1;
      wait_run();
      write_enable = 1'b1; address_to_mem = HALT; data_to_mem = 'h9A;
      @(negedge clk);
      write_enable = 1'b0;
      dump_ready = 1'b1;
      n_vec++; if (halted !== 1'b1 || halt_code !== 32'h9A || cycle_count !== 32'd1) begin n_bad++; $display("FAIL rerun_halt got halted=%0h code=%0h cnt=%0d exp 1 9A 1", halted, halt_code, cycle_count); end
      for (int cyc = 0; cyc < 300 && got < DUMP_WORDS; cyc++) begin
         if (dump_valid === 1'b1) begin
            n_vec++; if (dump_data !== DATA_W'(got * 4)) begin n_bad++; $display("FAIL b2b_word%0d got %0h exp %0h", got, dump_data, got * 4); end
            if (got == 0) first = cyc;
            last = cyc;
            got++;
         end
         @(negedge clk);
      end
      n_vec++; if (got != DUMP_WORDS) begin n_bad++; $display("FAIL b2b_count got %0d exp %0d", got, DUMP_WORDS); end
      n_vec++; if (last - first != DUMP_WORDS - 1) begin n_bad++; $display("FAIL b2b_rate got span %0d exp %0d", last - first, DUMP_WORDS - 1); end
      n_vec++; if (done !== 1'b1 || dump_valid !== 1'b0 || dump_rd_en !== 1'b0) begin n_bad++; $display("FAIL b2b_done got done=%0h valid=%0h rd_en=%0h exp 1 0 0", done, dump_valid, dump_rd_en); end
      dump_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DUMP_WORDS; i++) mem[i] = DATA_W'(i * 4);
      reset = 1'b1; write_enable = 1'b0; address_to_mem = '0; data_to_mem = '0; dump_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_hold();
      test_halt();
      test_dump_toggle();
      test_timeout();
      test_reset_mid_dump();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got still running exp finished");
      $fatal(1, "watchdog expired");
   end

endmodule
